// File: rtl/amt_recovery_ctrl.sv
// Architectural-state recovery sequencer: walks the AMT four entries per cycle
// and replays the {logical,physical} pairs onto the RMT write ports.
module amt_recovery_ctrl #(
    parameter int SIZE_RMT          = 32,
    parameter int SIZE_RMT_LOG      = 5,
    parameter int SIZE_PHYSICAL_LOG = 7
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  recoverReq_i,
    input  logic                                  commitValid_i,
    output logic                                  amtRdEn_o,
    output logic [SIZE_RMT_LOG-1:0]               amtRdAddr0_o,
    output logic [SIZE_RMT_LOG-1:0]               amtRdAddr1_o,
    output logic [SIZE_RMT_LOG-1:0]               amtRdAddr2_o,
    output logic [SIZE_RMT_LOG-1:0]               amtRdAddr3_o,
    input  logic [SIZE_PHYSICAL_LOG-1:0]          amtRdData0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]          amtRdData1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]          amtRdData2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]          amtRdData3_i,
    output logic                                  rmtWe_o,
    output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] recoverPacket0_o,
    output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] recoverPacket1_o,
    output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] recoverPacket2_o,
    output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] recoverPacket3_o,
    output logic                                  busy_o,
    output logic                                  recoverDone_o,
    output logic                                  protocolErr_o
);

    localparam int PKT_W = SIZE_RMT_LOG + SIZE_PHYSICAL_LOG;
    localparam logic [SIZE_RMT_LOG-1:0] LAST_CNT = SIZE_RMT_LOG'(SIZE_RMT - 4);

    typedef enum logic [1:0] {IDLE, WALK, LAST} state_e;

    state_e                         state_q, state_d;
    logic [SIZE_RMT_LOG-1:0]        cnt_q, cnt_d;
    logic                           rmt_we_q, rmt_we_d;
    logic                           busy_q, busy_d;
    logic                           err_q, err_d;
    logic [PKT_W-1:0]               pkt_q [4];
    logic [PKT_W-1:0]               pkt_d [4];
    logic [SIZE_PHYSICAL_LOG-1:0]   rd_data [4];
    logic [SIZE_RMT_LOG-1:0]        rd_addr [4];
    logic                           rd_en;
    logic                           done;

    assign rd_data[0] = amtRdData0_i;
    assign rd_data[1] = amtRdData1_i;
    assign rd_data[2] = amtRdData2_i;
    assign rd_data[3] = amtRdData3_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rmt_we_d = 1'b0;
        rd_en    = 1'b0;
        done     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pkt_d[k]   = pkt_q[k];
            rd_addr[k] = '0;
        end

        case (state_q)
            IDLE: begin
                if (recoverReq_i) begin
                    state_d = WALK;
                    cnt_d   = '0;
                end
            end
            WALK: begin
                // The group read this cycle is always written, even when a restart follows.
                rd_en    = 1'b1;
                rmt_we_d = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    rd_addr[k] = cnt_q + SIZE_RMT_LOG'(k);
                    pkt_d[k]   = {rd_addr[k], rd_data[k]};
                end
                if (recoverReq_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = LAST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SIZE_RMT_LOG'(4);
                end
            end
            LAST: begin
                if (recoverReq_i) begin
                    state_d = WALK;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
        err_d  = err_q | (commitValid_i & busy_q);
    end

    // Packets are cleared too so that every output reads zero while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rmt_we_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int k = 0; k < 4; k++) pkt_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rmt_we_q <= rmt_we_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            for (int k = 0; k < 4; k++) pkt_q[k] <= pkt_d[k];
        end
    end

    assign amtRdEn_o        = rd_en;
    assign amtRdAddr0_o     = rd_addr[0];
    assign amtRdAddr1_o     = rd_addr[1];
    assign amtRdAddr2_o     = rd_addr[2];
    assign amtRdAddr3_o     = rd_addr[3];
    assign rmtWe_o          = rmt_we_q;
    assign recoverPacket0_o = pkt_q[0];
    assign recoverPacket1_o = pkt_q[1];
    assign recoverPacket2_o = pkt_q[2];
    assign recoverPacket3_o = pkt_q[3];
    assign busy_o           = busy_q;
    assign recoverDone_o    = done;
    assign protocolErr_o    = err_q;

endmodule

// File: tb/tb_amt_recovery_ctrl.sv
// Directed bench for amt_recovery_ctrl with a combinational AMT model (AMT[i] = i + 64).
module tb_amt_recovery_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        recoverReq_i = 1'b0;
    logic        commitValid_i = 1'b0;
    logic        amtRdEn_o;
    logic [4:0]  addr [4];
    logic [6:0]  data [4];
    logic        rmtWe_o;
    logic [11:0] pk [4];
    logic        busy_o;
    logic        recoverDone_o;
    logic        protocolErr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_amt
        assign data[g] = {2'b00, addr[g]} + 7'd64;
    end

    amt_recovery_ctrl dut (
        .clk(clk), .reset(reset),
        .recoverReq_i(recoverReq_i), .commitValid_i(commitValid_i),
        .amtRdEn_o(amtRdEn_o),
        .amtRdAddr0_o(addr[0]), .amtRdAddr1_o(addr[1]),
        .amtRdAddr2_o(addr[2]), .amtRdAddr3_o(addr[3]),
        .amtRdData0_i(data[0]), .amtRdData1_i(data[1]),
        .amtRdData2_i(data[2]), .amtRdData3_i(data[3]),
        .rmtWe_o(rmtWe_o),
        .recoverPacket0_o(pk[0]), .recoverPacket1_o(pk[1]),
        .recoverPacket2_o(pk[2]), .recoverPacket3_o(pk[3]),
        .busy_o(busy_o), .recoverDone_o(recoverDone_o), .protocolErr_o(protocolErr_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [60:0] all_out;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            recoverReq_i  = 1'($urandom);
            commitValid_i = 1'($urandom);
            step();
            all_out = {amtRdEn_o, addr[0], addr[1], addr[2], addr[3], rmtWe_o,
                       pk[0], pk[1], pk[2], pk[3], busy_o, recoverDone_o, protocolErr_o};
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset_outputs got %h want 0", all_out);
            end
        end
        recoverReq_i  = 1'b0;
        commitValid_i = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (busy_o !== 1'b0 || rmtWe_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b we=%b want 0 0", busy_o, rmtWe_o);
        end
    endtask

    task automatic test_full_walk();
        logic [11:0] exp;
        recoverReq_i = 1'b1;
        step();
        recoverReq_i = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            checks++;
            if (busy_o !== (n <= 9)) begin
                errors++;
                $display("FAIL walk_busy cyc=%0d got %b want %b", n, busy_o, (n <= 9));
            end
            checks++;
            if (rmtWe_o !== (n >= 2 && n <= 9)) begin
                errors++;
                $display("FAIL walk_we cyc=%0d got %b", n, rmtWe_o);
            end
            checks++;
            if (recoverDone_o !== (n == 9)) begin
                errors++;
                $display("FAIL walk_done cyc=%0d got %b want %b", n, recoverDone_o, (n == 9));
            end
            checks++;
            if (amtRdEn_o !== (n <= 8)) begin
                errors++;
                $display("FAIL walk_rden cyc=%0d got %b", n, amtRdEn_o);
            end
            if (n <= 8) begin
                checks++;
                if (addr[0] !== 5'(4 * (n - 1)) || addr[3] !== 5'(4 * (n - 1) + 3)) begin
                    errors++;
                    $display("FAIL walk_addr cyc=%0d got %0d/%0d want %0d", n, addr[0], addr[3], 4 * (n - 1));
                end
            end
            if (n >= 2 && n <= 9) begin
                for (int k = 0; k < 4; k++) begin
                    exp = {5'(4 * (n - 2) + k), 7'(4 * (n - 2) + k + 64)};
                    checks++;
                    if (pk[k] !== exp) begin
                        errors++;
                        $display("FAIL walk_pkt%0d cyc=%0d got %h want %h", k, n, pk[k], exp);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_restart();
        recoverReq_i = 1'b1;
        step();
        recoverReq_i = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            if (n == 4) recoverReq_i = 1'b1;
            #1;
            checks++;
            if (recoverDone_o !== (n == 13)) begin
                errors++;
                $display("FAIL restart_done cyc=%0d got %b want %b", n, recoverDone_o, (n == 13));
            end
            checks++;
            if (busy_o !== (n <= 13)) begin
                errors++;
                $display("FAIL restart_busy cyc=%0d got %b want %b", n, busy_o, (n <= 13));
            end
            if (n == 5) begin
                checks++;
                if (addr[0] !== 5'd0 || amtRdEn_o !== 1'b1 || rmtWe_o !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_addr got addr0=%0d en=%b we=%b want 0 1 1", addr[0], amtRdEn_o, rmtWe_o);
                end
            end
            step();
            recoverReq_i = 1'b0;
        end
    endtask

    task automatic test_req_in_last();
        recoverReq_i = 1'b1;
        step();
        recoverReq_i = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            if (n == 9) begin
                recoverReq_i = 1'b1;
                #1;
                checks++;
                if (rmtWe_o !== 1'b1 || recoverDone_o !== 1'b0) begin
                    errors++;
                    $display("FAIL last_req got we=%b done=%b want 1 0", rmtWe_o, recoverDone_o);
                end
            end else begin
                checks++;
                if (recoverDone_o !== (n == 18)) begin
                    errors++;
                    $display("FAIL last_done cyc=%0d got %b want %b", n, recoverDone_o, (n == 18));
                end
            end
            if (n == 10 || n == 17) begin
                checks++;
                if (amtRdEn_o !== 1'b1 || addr[0] !== (n == 10 ? 5'd0 : 5'd28)) begin
                    errors++;
                    $display("FAIL last_walk cyc=%0d got en=%b addr0=%0d", n, amtRdEn_o, addr[0]);
                end
            end
            checks++;
            if (busy_o !== (n <= 18)) begin
                errors++;
                $display("FAIL last_busy cyc=%0d got %b want %b", n, busy_o, (n <= 18));
            end
            step();
            recoverReq_i = 1'b0;
        end
    endtask

    task automatic test_protocol_err();
        recoverReq_i = 1'b1;
        step();
        recoverReq_i = 1'b0;
        step();
        step();
        commitValid_i = 1'b1;
        checks++;
        if (protocolErr_o !== 1'b0) begin
            errors++;
            $display("FAIL perr_before got %b want 0", protocolErr_o);
        end
        step();
        commitValid_i = 1'b0;
        checks++;
        if (protocolErr_o !== 1'b1) begin
            errors++;
            $display("FAIL perr_set got %b want 1", protocolErr_o);
        end
        for (int i = 0; i < 8; i++) step();
        recoverReq_i = 1'b1;
        step();
        recoverReq_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (protocolErr_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL perr_hold got err=%b busy=%b want 1 0", protocolErr_o, busy_o);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (protocolErr_o !== 1'b0) begin
            errors++;
            $display("FAIL perr_clear got %b want 0", protocolErr_o);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        int done_seen;
        done_seen = 0;
        recoverReq_i = 1'b1;
        step();
        recoverReq_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (busy_o !== 1'b1 || rmtWe_o !== 1'b1 || amtRdEn_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got busy=%b we=%b en=%b want 1 1 1", busy_o, rmtWe_o, amtRdEn_o);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || rmtWe_o !== 1'b0 || amtRdEn_o !== 1'b0 || recoverDone_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_drop got busy=%b we=%b en=%b done=%b want 0 0 0 0",
                     busy_o, rmtWe_o, amtRdEn_o, recoverDone_o);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (recoverDone_o !== 1'b0 || busy_o !== 1'b0) done_seen++;
            step();
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL arst_after got %0d active cycles want 0", done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_full_walk();
        test_restart();
        test_req_in_last();
        test_protocol_err();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
